// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-variable struct, FSM encoding and the
// FIPS 180-4 mixing functions used by the round and the message schedule.
package sha256_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam work_t IV_WORK = '{IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word-wise mod 2^32 sum used for the end-of-block chaining update.
  function automatic work_t add_work(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working vars a..h plus K[t]
// and W[t] in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression of one 512-bit block, UNROLL rounds per clock,
// with a valid/ready block input and a valid/ready chaining-digest output.
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] message,
  input  logic         first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  localparam logic [5:0] T_STEP = 6'(UNROLL);
  localparam logic [5:0] T_LAST = 6'(64 - UNROLL);

  state_e      state_q;
  logic [5:0]  t_q;
  work_t       work_q;
  work_t       h_q;
  logic [31:0] win_q [16];
  logic [31:0] ext   [16 + UNROLL];
  work_t       chain [UNROLL + 1];

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign digest    = h_q;

  // win_q[0] always holds W[t], so round g of this cycle consumes win_q[g].
  assign chain[0] = work_q;

  for (genvar g = 0; g < int'(UNROLL); g++) begin : g_round
    logic [31:0] k_rnd;
    assign k_rnd = K[t_q + 6'(g)];

    sha256_round u_round (
      .cur (chain[g]),
      .k   (k_rnd),
      .w   (win_q[g]),
      .nxt (chain[g + 1])
    );
  end

  // Extend the window by UNROLL words so it can shift by a whole step per clock.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      ext[j] = win_q[j];
    end
    for (int j = 0; j < int'(UNROLL); j++) begin
      ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j]
                  + small_sigma0(ext[1 + j]) + ext[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      h_q     <= IV_WORK;
      work_q  <= '0;
      for (int j = 0; j < 16; j++) begin
        win_q[j] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            for (int j = 0; j < 16; j++) begin
              win_q[j] <= message[511 - 32*j -: 32];
            end
            work_q  <= first ? IV_WORK : h_q;
            if (first) begin
              h_q <= IV_WORK;
            end
            t_q     <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          work_q <= chain[UNROLL];
          for (int j = 0; j < 16; j++) begin
            win_q[j] <= ext[j + int'(UNROLL)];
          end
          t_q <= t_q + T_STEP;
          if (t_q == T_LAST) begin
            h_q     <= add_work(h_q, chain[UNROLL]);
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed known-answer bench: four engines (UNROLL 1/2/4/8) share clock and
// reset; back-pressure and mid-block reset are exercised on the UNROLL=1 engine.
module tb_sha256_round_engine;

  logic         clk;
  logic         rst;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [511:0] message   [4];
  logic         first     [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [255:0] digest    [4];
  logic         busy      [4];

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_M   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_M = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO_M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_M2  = {{15{32'h0}}, 32'h000001c0};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_round_engine #(.UNROLL(1 << g)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .message   (message[g]),
      .first     (first[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .digest    (digest[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for out_valid on engine d, counting rising edges since the accept edge.
  task automatic wait_done(input int d, output int cyc);
    cyc = 0;
    while (!out_valid[d] && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_block(input int d, input logic [511:0] msg, input logic f,
                           input logic chk, input logic [255:0] exp, input string tag);
    int cyc;
    @(negedge clk);
    message[d]  = msg;
    first[d]    = f;
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    message[d]  = '1;
    first[d]    = ~f;
    check({tag, " accepted"}, {255'b0, in_ready[d]}, 256'd0);
    check({tag, " busy"}, {255'b0, busy[d]}, 256'd1);
    wait_done(d, cyc);
    check({tag, " latency"}, 256'(cyc), 256'(64 >> d));
    if (chk) check({tag, " digest"}, digest[d], exp);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check({tag, " idle after handoff"}, {254'b0, in_ready[d], out_valid[d]}, 256'b10);
    if (chk) check({tag, " digest held"}, digest[d], exp);
  endtask

  initial begin
    int cyc;
    int unstable;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      first[i]     = 1'b0;
      message[i]   = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d reset flags", 1 << i),
            {253'b0, in_ready[i], out_valid[i], busy[i]}, 256'b100);
      check($sformatf("u%0d reset digest", 1 << i), digest[i], IV_D);
    end
    rst = 1'b0;

    for (int d = 0; d < 4; d++) begin
      run_block(d, ABC_M,   1'b1, 1'b1, ABC_D,   $sformatf("u%0d abc", 1 << d));
      run_block(d, EMPTY_M, 1'b1, 1'b1, EMPTY_D, $sformatf("u%0d empty", 1 << d));
      run_block(d, TWO_M1,  1'b1, 1'b0, '0,      $sformatf("u%0d two-blk1", 1 << d));
      run_block(d, TWO_M2,  1'b0, 1'b1, TWO_D,   $sformatf("u%0d two-blk2", 1 << d));
    end

    // Back-pressure: in_valid stays high throughout, out_ready low for 20 cycles.
    @(negedge clk);
    message[0]  = ABC_M;
    first[0]    = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    message[0] = EMPTY_M;
    wait_done(0, cyc);
    check("bp first latency", 256'(cyc), 256'd64);
    unstable = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (digest[0] !== ABC_D || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) unstable++;
    end
    check("bp stall stable", 256'(unstable), 256'd0);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    check("bp idle after handoff", {255'b0, in_ready[0]}, 256'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("bp second accepted", {254'b0, in_ready[0], busy[0]}, 256'b01);
    wait_done(0, cyc);
    check("bp second latency", 256'(cyc), 256'd64);
    check("bp second digest", digest[0], EMPTY_D);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;

    // Reset while round 30 of a block is in flight.
    @(negedge clk);
    message[0]  = ABC_M;
    first[0]    = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid-run reset flags", {253'b0, in_ready[0], out_valid[0], busy[0]}, 256'b100);
    check("mid-run reset digest", digest[0], IV_D);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, ABC_M, 1'b0, 1'b1, ABC_D, "post-reset abc first=0");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sha256_round_engine.md
# sha256_round_engine

Iterative SHA-256 compression core that succeeds the single-stage round-constant adder with a full 64-round compression of one 512-bit block. Blocks are handed in over a valid/ready handshake and the 256-bit chaining digest is returned over a second valid/ready handshake. Blocks can start a new message from the standard IV or chain onto the previous digest. Rounds per cycle are parametrised so one RTL source covers area-lean and throughput-oriented builds in the hashing datapath.

## Interface
- UNROLL, 1, rounds evaluated per clock; legal values 1, 2, 4, 8; N = 64/UNROLL
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  block offered
- in_ready  output  1  engine can accept a block; high only in IDLE
- message  input  512  padded block, big-endian words: W0 = message[511:480], W15 = message[31:0]
- first  input  1  sampled with message; 1 = start from IV, 0 = chain from held digest
- out_valid  output  1  digest available
- out_ready  input  1  consumer accepts digest
- digest  output  256  chaining value H0..H7; H0 = digest[255:224]
- busy  output  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch 16-word W window from message; load working vars a..h from IV if first=1, else from H register; round counter t=0; go RUN. If first=1, the H register is also loaded with IV.
- RUN: each cycle apply UNROLL rounds t..t+UNROLL-1 using K[t] and W[t]. For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], produced from a shifting 16-word window. t += UNROLL. On the cycle processing round 63: H[i] <= H[i] + working[i], each word mod 2^32; go DONE.
- DONE: out_valid=1; digest = H. On out_ready: go IDLE. H is retained for chaining.
- Arithmetic: all adds are 32-bit wrapping. Σ0/Σ1/σ0/σ1/Ch/Maj are per FIPS 180-4.
- message and first are ignored outside the accept handshake.
- in_valid held in RUN/DONE is not accepted and is not lost. The block is taken in the first IDLE cycle.
- digest is stable while out_valid && !out_ready, and is held after handoff.
- Reset (any state, including mid-RUN): state=IDLE, H=IV, t=0. Outputs: in_ready=1, out_valid=0, busy=0, digest=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). Any partial block is discarded.
- first=0 straight after reset chains from IV, which is equivalent to first=1.

## Timing
- Accept edge E0. Round edges E1..EN. out_valid is visible after EN, so latency is N cycles (64 for UNROLL=1, 8 for UNROLL=8).
- With in_valid and out_ready held high, the block period is N+2 cycles: accept, N rounds, digest handoff.
- in_ready, out_valid and busy decode directly from the state register, with no combinational path from in_valid or out_ready.
- Critical path is UNROLL chained rounds; timing closure at UNROLL>2 is the integrator's responsibility.

## Structure
- sha256_pkg holds:
  - K[0:63] constant array
  - IV[0:7]
  - the state enum
  - functions for Σ0, Σ1, σ0, σ1, Ch, Maj
- Sub-module sha256_round is one combinational round: inputs a..h, K, W; outputs next a..h. It is instantiated UNROLL times in a chain by generate.
- The schedule window and control FSM stay in the top module.

## Test plan
- "abc" block (message = 0x61626380, then 0s, ending 0x00000018), first=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid exactly N cycles after accept.
- Empty-string block (0x80000000, then 0s), first=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 448-bit message "abcdbcdecdef…nopq", two blocks: first=1, then first=0 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Back-pressure: hold out_ready=0 for 20 cycles with in_valid=1 -> digest constant, in_ready=0, second block accepted the cycle after out handshake.
- Reset asserted at t=30 of a block -> all outputs at reset values immediately; the next "abc" block hashes correctly.
- Repeat the first three scenarios for UNROLL = 1, 2, 4, 8 -> identical digests, latency 64/32/16/8.
